// File: rtl/alarm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alarm_sequencer
// Description : Alarm control FSM (DISARMED/ARMED/RINGING/SNOOZE) that matches
//               BCD current time against alarm time and owns the ring/snooze
//               countdown. Optional macro ALARM_BLINK_EN selects a 0.5 Hz
//               buzzer pattern instead of a steady level.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_sequencer #(
    parameter int SNOOZE_SEC = 300,
    parameter int RING_SEC   = 60,
    parameter int CNT_W      = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sec_tick,
    input  logic             settime,
    input  logic             arm_key,
    input  logic             dismiss_key,
    input  logic             snooze_key,
    input  logic [23:0]      cur_time,
    input  logic [23:0]      alm_time,
    output logic [1:0]       state,
    output logic             armed,
    output logic             ringing,
    output logic             buzzer,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SEC);
    localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SEC);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_d;
    logic             eq;
    logic             eq_q;
    logic             match;

    // Edge-detect equality so a held match fires once; eq_q resets high so
    // the all-zero reset times never count as a fresh match.
    assign eq    = (cur_time == alm_time) & ~settime;
    assign match = eq & ~eq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= ST_DISARMED;
            rem_q     <= '0;
            eq_q      <= 1'b1;
        end else begin
            cur_state <= nxt_state;
            rem_q     <= rem_d;
            eq_q      <= eq;
        end
    end

    // Branch order encodes event priority; a key that acts swallows the tick.
    always_comb begin
        nxt_state = cur_state;
        rem_d     = rem_q;
        unique case (cur_state)
            ST_DISARMED: begin
                rem_d = '0;
                if (arm_key) begin
                    nxt_state = ST_ARMED;
                end
            end
            ST_ARMED: begin
                rem_d = '0;
                if (arm_key) begin
                    nxt_state = ST_DISARMED;
                end else if (match) begin
                    nxt_state = ST_RINGING;
                    rem_d     = RING_LOAD;
                end
            end
            ST_RINGING: begin
                if (arm_key) begin
                    nxt_state = ST_DISARMED;
                    rem_d     = '0;
                end else if (dismiss_key) begin
                    nxt_state = ST_ARMED;
                    rem_d     = '0;
                end else if (snooze_key) begin
                    nxt_state = ST_SNOOZE;
                    rem_d     = SNOOZE_LOAD;
                end else if (sec_tick) begin
                    if (rem_q <= CNT_ONE) begin
                        nxt_state = ST_ARMED;
                        rem_d     = '0;
                    end else begin
                        rem_d = rem_q - CNT_ONE;
                    end
                end
            end
            ST_SNOOZE: begin
                if (arm_key) begin
                    nxt_state = ST_DISARMED;
                    rem_d     = '0;
                end else if (dismiss_key) begin
                    nxt_state = ST_ARMED;
                    rem_d     = '0;
                end else if (sec_tick) begin
                    if (rem_q <= CNT_ONE) begin
                        nxt_state = ST_RINGING;
                        rem_d     = RING_LOAD;
                    end else begin
                        rem_d = rem_q - CNT_ONE;
                    end
                end
            end
            default: begin
                nxt_state = ST_DISARMED;
                rem_d     = '0;
            end
        endcase
    end

    assign state     = cur_state;
    assign armed     = (cur_state != ST_DISARMED);
    assign ringing   = (cur_state == ST_RINGING);
    assign remaining = rem_q;

`ifdef ALARM_BLINK_EN
    logic buzz_q;
    logic buzz_d;
    logic ring_tick;

    // Staying in RINGING across a tick is only possible via the decrement path.
    assign ring_tick = (cur_state == ST_RINGING) && (nxt_state == ST_RINGING) && sec_tick;

    always_comb begin
        buzz_d = 1'b0;
        if (nxt_state == ST_RINGING) begin
            if (cur_state != ST_RINGING) begin
                buzz_d = 1'b1;
            end else if (ring_tick) begin
                buzz_d = ~buzz_q;
            end else begin
                buzz_d = buzz_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buzz_q <= 1'b0;
        end else begin
            buzz_q <= buzz_d;
        end
    end

    assign buzzer = buzz_q;
`else
    assign buzzer = ringing;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_sequencer
// Description : Directed self-checking bench for alarm_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_sequencer;

    localparam int CNT_W = 9;

    logic             clk;
    logic             reset;
    logic             sec_tick;
    logic             settime;
    logic             arm_key;
    logic             dismiss_key;
    logic             snooze_key;
    logic [23:0]      cur_time;
    logic [23:0]      alm_time;
    logic [1:0]       state;
    logic             armed;
    logic             ringing;
    logic             buzzer;
    logic [CNT_W-1:0] remaining;

    int vectors;
    int miscompares;

    alarm_sequencer #(
        .SNOOZE_SEC (300),
        .RING_SEC   (60),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sec_tick    (sec_tick),
        .settime     (settime),
        .arm_key     (arm_key),
        .dismiss_key (dismiss_key),
        .snooze_key  (snooze_key),
        .cur_time    (cur_time),
        .alm_time    (alm_time),
        .state       (state),
        .armed       (armed),
        .ringing     (ringing),
        .buzzer      (buzzer),
        .remaining   (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks state-derived outputs; in the steady build buzzer must follow ringing.
    task automatic chk_st(input string tag, input logic [1:0] st, input int rem);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".remaining"}, 32'(remaining), 32'(rem));
        chk({tag, ".armed"}, 32'(armed), 32'(st != 2'd0));
        chk({tag, ".ringing"}, 32'(ringing), 32'(st == 2'd2));
`ifndef ALARM_BLINK_EN
        chk({tag, ".buzzer"}, 32'(buzzer), 32'(st == 2'd2));
`else
        if (st != 2'd2) chk({tag, ".buzzer_off"}, 32'(buzzer), 32'd0);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sec_tick = 1'b1;
            cycle();
            sec_tick = 1'b0;
        end
    endtask

    task automatic pulse_arm();
        arm_key = 1'b1;
        cycle();
        arm_key = 1'b0;
    endtask

    // Produces a fresh rising edge of equality at 07:30:00.
    task automatic hit_alarm();
        cur_time = 24'h072959;
        cycle();
        cur_time = 24'h073000;
        cycle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        sec_tick    = 1'b0;
        settime     = 1'b0;
        arm_key     = 1'b0;
        dismiss_key = 1'b0;
        snooze_key  = 1'b0;
        cur_time    = 24'h000000;
        alm_time    = 24'h000000;
        cycle();
        cycle();
        chk_st("reset", 2'd0, 0);
        reset = 1'b0;
        cycle();

        // Equal zero times after reset must not ring
        pulse_arm();
        chk_st("arm", 2'd1, 0);
        cycle(); cycle(); cycle();
        chk_st("zero_eq_hold", 2'd1, 0);

        // Alarm fires on edge of equality, then times out after 60 ticks
        alm_time = 24'h073000;
        hit_alarm();
        chk_st("ring_start", 2'd2, 60);
        ticks(59);
        chk_st("ring_59", 2'd2, 1);
        ticks(1);
        chk_st("ring_timeout", 2'd1, 0);
        cycle(); cycle();
        chk_st("held_eq_no_retrig", 2'd1, 0);

        // Snooze: key beats a coincident tick; 300 ticks re-ring
        hit_alarm();
        chk_st("ring2", 2'd2, 60);
        ticks(2);
        chk_st("ring2_dec", 2'd2, 58);
        snooze_key = 1'b1;
        sec_tick   = 1'b1;
        cycle();
        snooze_key = 1'b0;
        sec_tick   = 1'b0;
        chk_st("snooze_key_tick", 2'd3, 300);
        ticks(299);
        chk_st("snooze_299", 2'd3, 1);
        snooze_key = 1'b1;
        cycle();
        snooze_key = 1'b0;
        chk_st("snooze_key_ignored", 2'd3, 1);
        ticks(1);
        chk_st("snooze_rering", 2'd2, 60);
`ifdef ALARM_BLINK_EN
        chk("blink0", 32'(buzzer), 32'd1);
        ticks(1);
        chk("blink1", 32'(buzzer), 32'd0);
        ticks(1);
        chk("blink2", 32'(buzzer), 32'd1);
        ticks(1);
        chk("blink3", 32'(buzzer), 32'd0);
`else
        ticks(3);
`endif
        chk_st("ring_after3", 2'd2, 57);
        dismiss_key = 1'b1;
        sec_tick    = 1'b1;
        cycle();
        dismiss_key = 1'b0;
        sec_tick    = 1'b0;
        chk_st("dismiss_tick", 2'd1, 0);

        // arm_key outranks dismiss_key
        hit_alarm();
        chk_st("ring3", 2'd2, 60);
        arm_key     = 1'b1;
        dismiss_key = 1'b1;
        cycle();
        arm_key     = 1'b0;
        dismiss_key = 1'b0;
        chk_st("arm_dismiss", 2'd0, 0);

        // DISARMED ignores dismiss, snooze, match
        dismiss_key = 1'b1;
        cycle();
        dismiss_key = 1'b0;
        snooze_key  = 1'b1;
        cycle();
        snooze_key  = 1'b0;
        hit_alarm();
        chk_st("disarmed_ignore", 2'd0, 0);

        // settime masks the match; release makes a new edge
        pulse_arm();
        cur_time = 24'h072959;
        cycle();
        settime  = 1'b1;
        cur_time = 24'h073000;
        cycle(); cycle(); cycle();
        chk_st("settime_block", 2'd1, 0);
        settime = 1'b0;
        cycle();
        chk_st("settime_release", 2'd2, 60);
        ticks(1);
        chk_st("ring4_dec", 2'd2, 59);

        // Asynchronous reset mid-ring
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_st("async_reset", 2'd0, 0);
        cycle();
        reset = 1'b0;
        pulse_arm();
        cycle(); cycle();
        chk_st("post_reset_eq_hold", 2'd1, 0);
        pulse_arm();
        chk_st("disarm", 2'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
